// File: rtl/inst_rom_resp.sv
// Instruction-memory responder for the fetch port: programmable wait states,
// stall request while a word is pending, error flag for misaligned/out-of-range fetches.
module inst_rom_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  req_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_req_o,
    input  logic                  load_we_i,
    input  logic [DEPTH_LOG2-1:0] load_addr_i,
    input  logic [31:0]           load_data_i,
    output logic                  busy_o
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [31:0]           r_mem [DEPTH];
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_err;
    logic [31:0]           r_inst;
    logic                  r_ack;
    logic                  r_err_o;

    logic                  w_accept;
    logic                  w_new_err;
    logic [DEPTH_LOG2-1:0] w_new_idx;
    logic                  w_load_ok;

    always_comb begin
        w_accept  = ce_i & req_i & ((r_state == S_IDLE) | (r_state == S_RESP));
        w_new_err = (|addr_i[1:0]) | (|addr_i[31:DEPTH_LOG2+2]);
        w_new_idx = addr_i[DEPTH_LOG2+1:2];
        // Fetch always wins: a load only lands in a truly idle cycle.
        w_load_ok = load_we_i & (r_state == S_IDLE) & ~w_accept;
    end

    assign busy_o      = load_we_i & ~w_load_ok;
    assign stall_req_o = (r_state == S_WAIT) | (w_accept & (WAIT_CYCLES != 0));
    assign inst_o      = r_inst;
    assign ack_o       = r_ack;
    assign err_o       = r_err_o;

    // Program storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_load_ok) begin
            r_mem[load_addr_i] <= load_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_inst  <= '0;
            r_ack   <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            r_err_o <= 1'b0;
            r_inst  <= '0;
            if (!ce_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_idx <= w_new_idx;
                r_err <= w_new_err;
                if (WAIT_CYCLES == 0) begin
                    r_state <= S_RESP;
                    r_ack   <= 1'b1;
                    r_err_o <= w_new_err;
                    r_inst  <= w_new_err ? '0 : r_mem[w_new_idx];
                end else begin
                    r_state <= S_WAIT;
                    r_cnt   <= CNT_INIT;
                end
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (r_cnt == '0) begin
                            r_state <= S_RESP;
                            r_ack   <= 1'b1;
                            r_err_o <= r_err;
                            r_inst  <= r_err ? '0 : r_mem[r_idx];
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
